// File: rtl/ring_uart_tx.sv
// Pops one word per frame from the ring buffer and shifts it out as start, LSB-first data, stop bits.
// Three idle-high cycles (IDLE/REQ/ACK) precede every frame; a missing read ack simply returns to IDLE.
module ring_uart_tx #(
  parameter int WordSize     = 8,
  parameter int ClocksPerBit = 868,
  parameter int CounterBits  = 16,
  parameter int StopBits     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                txEnable,
  input  logic [31:0]         bufferLength,
  output logic                dataReadEnable,
  input  logic                dataReadAck,
  input  logic [WordSize-1:0] dataRead,
  output logic                tx,
  output logic                busy,
  output logic [31:0]         bytesSent
);

  // bitCnt also indexes stop bits, so it must cover StopBits-1 as well as WordSize-1
  localparam int BitCntBits = (WordSize > 1) ? $clog2(WordSize) : 1;

  localparam logic [CounterBits-1:0] ClkLast  = CounterBits'(ClocksPerBit - 1);
  localparam logic [CounterBits-1:0] ClkOne   = CounterBits'(1);
  localparam logic [BitCntBits-1:0]  DataLast = BitCntBits'(WordSize - 1);
  localparam logic [BitCntBits-1:0]  StopLast = BitCntBits'(StopBits - 1);
  localparam logic [BitCntBits-1:0]  BitOne   = BitCntBits'(1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state, state_d;
  logic [WordSize-1:0]   shift, shift_d;
  logic [CounterBits-1:0] clkCnt, clkCnt_d;
  logic [BitCntBits-1:0] bitCnt, bitCnt_d;
  logic                  tx_d;
  logic                  busy_d;
  logic                  dataReadEnable_d;
  logic [31:0]           bytesSent_d;
  logic                  bitEnd;

  assign bitEnd = (clkCnt == ClkLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      shift          <= '0;
      clkCnt         <= '0;
      bitCnt         <= '0;
      tx             <= 1'b1;
      busy           <= 1'b0;
      dataReadEnable <= 1'b0;
      bytesSent      <= 32'd0;
    end else begin
      state          <= state_d;
      shift          <= shift_d;
      clkCnt         <= clkCnt_d;
      bitCnt         <= bitCnt_d;
      tx             <= tx_d;
      busy           <= busy_d;
      dataReadEnable <= dataReadEnable_d;
      bytesSent      <= bytesSent_d;
    end
  end

  always_comb begin
    state_d          = state;
    shift_d          = shift;
    clkCnt_d         = clkCnt;
    bitCnt_d         = bitCnt;
    tx_d             = tx;
    busy_d           = busy;
    dataReadEnable_d = 1'b0;
    bytesSent_d      = bytesSent;

    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (txEnable && (bufferLength != 32'd0)) begin
          dataReadEnable_d = 1'b1;
          busy_d           = 1'b1;
          state_d          = REQ;
        end
      end

      REQ: state_d = ACK;

      // The buffer's ack is sticky, so this is the only cycle it means anything
      ACK: begin
        if (dataReadAck) begin
          shift_d  = dataRead;
          tx_d     = 1'b0;
          bitCnt_d = '0;
          clkCnt_d = '0;
          state_d  = START;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      START: begin
        if (bitEnd) begin
          tx_d     = shift[0];
          shift_d  = shift >> 1;
          clkCnt_d = '0;
          state_d  = DATA;
        end else begin
          clkCnt_d = clkCnt + ClkOne;
        end
      end

      DATA: begin
        if (bitEnd) begin
          clkCnt_d = '0;
          if (bitCnt == DataLast) begin
            tx_d     = 1'b1;
            bitCnt_d = '0;
            state_d  = STOP;
          end else begin
            tx_d     = shift[0];
            shift_d  = shift >> 1;
            bitCnt_d = bitCnt + BitOne;
          end
        end else begin
          clkCnt_d = clkCnt + ClkOne;
        end
      end

      STOP: begin
        if (bitEnd) begin
          clkCnt_d = '0;
          if (bitCnt == StopLast) begin
            bitCnt_d    = '0;
            bytesSent_d = bytesSent + 32'd1;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end else begin
            bitCnt_d = bitCnt + BitOne;
          end
        end else begin
          clkCnt_d = clkCnt + ClkOne;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ring_uart_tx.md
Name: ring_uart_tx

Overview:
- Drain side of the byte ring buffer: requests one word at a time over the buffer's read handshake and serialises it onto an asynchronous serial line.
- Frame format: 8N1-style (start bit, WordSize data bits LSB first, StopBits stop bits).
- Sits between the CPU-fed output buffer and the board TX pin; exactly one reader per buffer instance.

Parameters:
WordSize, 8, data bits per frame; must equal the buffer word width
ClocksPerBit, 868, clk cycles per serial bit (100 MHz / 115200)
CounterBits, 16, width of bit-period counter; must hold ClocksPerBit-1
StopBits, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  global clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
txEnable  input  1  when 1, idle block may fetch new words; frame in flight always completes
bufferLength  input  32  buffer occupancy (registered, one cycle stale); used only as nonzero hint
dataReadEnable  output  1  read request to buffer, one-cycle pulse
dataReadAck  input  1  buffer read success, valid only the cycle after the request
dataRead  input  WordSize  word returned by buffer, valid with dataReadAck
tx  output  1  serial line, idle high
busy  output  1  1 from REQ through last stop-bit cycle
bytesSent  output  32  count of completed frames, wraps at 2^32

Behaviour:
- Reset (async): state=IDLE, tx=1, dataReadEnable=0, busy=0, bytesSent=0, counters=0. Abort any frame mid-flight; tx high immediately. A popped-but-unsent word is lost, not re-queued.
- All outputs registered.
- States: IDLE, REQ, ACK, START, DATA, STOP.
- IDLE:
  - If txEnable=1 and bufferLength!=0: dataReadEnable<=1, busy<=1, go REQ.
  - Otherwise stay; tx=1.
- REQ (dataReadEnable high this cycle): dataReadEnable<=0, go ACK.
- ACK: sample dataReadAck exactly this cycle. The buffer's ack is sticky and stays high after a read, so it is never sampled in any other state.
  - Ack=1: shift<=dataRead, tx<=0, bitCnt<=0, clkCnt<=0, go START.
  - Ack=0 (empty, or simultaneous writer collision, since the buffer gives write priority): busy<=0, go IDLE. Retry naturally; no error flag.
- START: tx=0 for ClocksPerBit cycles. On clkCnt==ClocksPerBit-1: tx<=shift[0], shift>>=1, go DATA.
- DATA: each bit held ClocksPerBit cycles, LSB first.
  - After bit WordSize-1 period: tx<=1, go STOP.
  - Otherwise drive next bit.
- STOP: tx=1 for StopBits*ClocksPerBit cycles. At end: bytesSent<=bytesSent+1, busy<=0, go IDLE.
- Frame length: (1+WordSize+StopBits)*ClocksPerBit cycles of tx activity.
- Inter-frame gap: minimum 3 extra idle-high cycles (IDLE, REQ, ACK) between back-to-back frames.
- Clearing txEnable mid-frame: no effect until IDLE.
- bufferLength stale by one cycle: may trigger a request on an empty buffer. That request is harmless and must resolve as ack=0.
- clkCnt: counts 0..ClocksPerBit-1, resets on every bit boundary.
- bitCnt: counts 0..WordSize-1.
- dataReadEnable must never be high two consecutive cycles.

Test Plan (ClocksPerBit=4, StopBits=1 unless noted):
- Reset, buffer holds 0xA5, txEnable=1 -> one dataReadEnable pulse. After ACK, tx=0 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then stop high 4 cycles. bytesSent=1, busy=0.
- Buffer holds 0x01,0x80 -> two frames in order. Gap between stop end and next start exactly 3 cycles high. bytesSent=2.
- Writer asserts dataWriteEnable in the same cycle as dataReadEnable -> ack=0. Block returns to IDLE, retries, then transmits the word. No tx glitch, bytesSent increments once.
- Empty buffer with bufferLength forced 1 for one cycle -> request issued, ack=0, tx stays 1, bytesSent unchanged, busy drops after ACK.
- txEnable=0 with data present -> no requests. Dropping txEnable mid-frame -> frame completes, no further fetch.
- Reset asserted mid-DATA of 0x3C -> tx=1 and busy=0 same edge. After release, the next buffered word is sent. bytesSent=0 before that frame.
